// File: rtl/ram_arbiter_pkg.sv
// Shared defaults, owner tag type and helpers for the CPU/DMA single-port RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned AW_DEF         = 8;
  localparam int unsigned DW_DEF         = 8;
  localparam int unsigned STARVE_MAX_DEF = 4;

  localparam int unsigned       CNT_W   = 4;
  localparam logic [CNT_W-1:0]  CNT_SAT = '1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } own_e;

  // Owner of the read whose data returns on ram_q in the following cycle.
  function automatic own_e read_owner(input logic gnt_cpu, input logic we_cpu,
                                      input logic gnt_dma, input logic we_dma);
    if (gnt_cpu && !we_cpu) return OWN_CPU;
    if (gnt_dma && !we_dma) return OWN_DMA;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester ports (CPU, DMA) and RAM port bundle for ram_arbiter.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic [DW-1:0] dma_rdata;
  logic          dma_rvalid;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output ram_addr, ram_data, ram_wren,
    input  ram_q
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  ram_addr, ram_data, ram_wren,
    output ram_q
  );

endinterface

// File: rtl/ram_arb_starve.sv
// Saturating count of consecutive cycles the DMA port was kept waiting.
module ram_arb_starve
  import ram_arbiter_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_SAT)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// CPU-priority arbiter for one synchronous single-port RAM, with a starvation
// limit that forces a DMA grant and read-data steering by a registered owner tag.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input logic          Clock,
  input logic          Reset,
  ram_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             starve_inc;
  logic             starve_clr;
  logic             force_dma;
  logic             cpu_gnt;
  logic             dma_gnt;

  logic [AW-1:0]    addr_shadow;
  logic [AW-1:0]    addr_sel;
  logic [DW-1:0]    wdata_sel;
  logic             wren_sel;

  own_e             rd_own;
  own_e             rd_own_nxt;

  ram_arb_starve u_starve (
    .Clock (Clock),
    .Reset (Reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .cnt   (starve_cnt)
  );

  // Grants are gated by Reset so nothing issues in a reset cycle.
  always_comb begin
    force_dma  = bus.dma_req && (starve_cnt >= STARVE_LIM);
    cpu_gnt    = !Reset && bus.cpu_req && !force_dma;
    dma_gnt    = !Reset && bus.dma_req && !cpu_gnt;
    starve_inc = bus.dma_req && !dma_gnt;
    starve_clr = !starve_inc;
  end

  // With no grant the address holds the last issued one, so an idle RAM sees a stable bus.
  always_comb begin
    addr_sel  = addr_shadow;
    wdata_sel = bus.cpu_wdata;
    wren_sel  = 1'b0;
    if (cpu_gnt) begin
      addr_sel  = bus.cpu_addr;
      wdata_sel = bus.cpu_wdata;
      wren_sel  = bus.cpu_we;
    end else if (dma_gnt) begin
      addr_sel  = bus.dma_addr;
      wdata_sel = bus.dma_wdata;
      wren_sel  = bus.dma_we;
    end
  end

  always_comb begin
    rd_own_nxt = read_owner(cpu_gnt, bus.cpu_we, dma_gnt, bus.dma_we);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_own      <= OWN_NONE;
      addr_shadow <= '0;
    end else begin
      rd_own      <= rd_own_nxt;
      addr_shadow <= addr_sel;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.ram_addr   = addr_sel;
  assign bus.ram_data   = wdata_sel;
  assign bus.ram_wren   = wren_sel;

  // rd_own still holds the pre-reset owner during the reset cycle, so valids are gated too.
  assign bus.cpu_rvalid = !Reset && (rd_own == OWN_CPU);
  assign bus.dma_rvalid = !Reset && (rd_own == OWN_DMA);
  assign bus.cpu_rdata  = bus.ram_q;
  assign bus.dma_rdata  = bus.ram_q;

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 8, RAM address width.
REQ-002 Parameter DW, default 8, RAM data width.
REQ-003 Parameter STARVE_MAX, default 4, consecutive DMA-denied cycles before forced DMA grant; legal range 1..15.
REQ-004 Clock  input  1  sole clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 cpu_req  input  1  CPU data-port access request.
REQ-007 cpu_we  input  1  CPU write (1) / read (0).
REQ-008 cpu_addr  input  AW  CPU address.
REQ-009 cpu_wdata  input  DW  CPU write data.
REQ-010 cpu_gnt  output  1  CPU access issued this cycle; low means the CPU stalls.
REQ-011 cpu_rdata  output  DW  CPU read data.
REQ-012 cpu_rvalid  output  1  cpu_rdata valid this cycle.
REQ-013 dma_req, dma_we, dma_addr, dma_wdata  input  1/1/AW/DW  DMA/loader port, same meaning as the CPU equivalents.
REQ-014 dma_gnt, dma_rdata, dma_rvalid  output  1/DW/1  DMA equivalents of cpu_gnt/cpu_rdata/cpu_rvalid.
REQ-015 ram_addr  output  AW  address to the single-port synchronous RAM.
REQ-016 ram_data  output  DW  write data to the RAM.
REQ-017 ram_wren  output  1  RAM write enable.
REQ-018 ram_q  input  DW  RAM read data, valid one cycle after the address is presented.

Function
REQ-019 At most one of cpu_gnt and dma_gnt SHALL be high in any cycle.
REQ-020 Grants SHALL be combinational from the current requests and the registered starvation count, so access issues in the same cycle as the request.
REQ-021 Default priority SHALL be CPU: cpu_req=1 gives cpu_gnt=1, unless forced-DMA (REQ-023) applies.
REQ-022 With dma_req=1 and no CPU grant, dma_gnt SHALL be 1.
REQ-023 When starve_cnt>=STARVE_MAX and dma_req=1, dma_gnt SHALL be 1 and cpu_gnt SHALL be 0 even if cpu_req=1.
REQ-024 starve_cnt behaviour on each cycle:
- dma_req=1 and dma_gnt=0: increment, saturating at 15.
- dma_gnt=1 or dma_req=0: clear to 0.
REQ-025 ram_addr and ram_data SHALL carry the granted requester's addr and wdata; ram_wren = granted requester's we.
REQ-026 With no grant, ram_wren SHALL be 0 and ram_addr SHALL hold its previous value (registered shadow).
REQ-027 A granted read SHALL set the registered owner tag rd_own to OWN_CPU or OWN_DMA; otherwise rd_own is OWN_NONE.
REQ-028 cpu_rvalid SHALL be 1 exactly one cycle after a CPU read grant, when rd_own=OWN_CPU; dma_rvalid is the DMA equivalent.
REQ-029 cpu_rdata and dma_rdata SHALL both drive ram_q; each is meaningful only while its rvalid is high.
REQ-030 A granted write SHALL produce no rvalid.
REQ-031 Back-to-back grants to alternating owners SHALL be supported every cycle with no bubble.

Reset
REQ-032 While Reset=1, the following SHALL hold:
- starve_cnt=0, rd_own=OWN_NONE, ram_addr shadow=0.
- cpu_gnt=0, dma_gnt=0, ram_wren=0, cpu_rvalid=0, dma_rvalid=0.
REQ-033 Reset asserted with a read in flight SHALL drop that read's rvalid; no grant SHALL issue in the reset cycle.
REQ-034 Arbitration SHALL resume normally in the first cycle after Reset deasserts.

Structure
REQ-035 A shared package SHALL hold AW/DW defaults, STARVE_MAX default and the owner enum {OWN_NONE, OWN_CPU, OWN_DMA}.
REQ-036 The saturating starvation counter SHALL be the sub-module ram_arb_starve, with inputs Clock, Reset, inc, clr and output cnt[3:0].

Verification
REQ-037 Scenario: CPU read only. cpu_req=1, we=0, addr=0x10, RAM holds 0x5A -> cpu_gnt=1 in cycle N; cpu_rvalid=1 with cpu_rdata=0x5A in cycle N+1.
REQ-038 Scenario: both ports request a write, starve_cnt=0. cpu addr 0x20/data 0x11, dma addr 0x30/data 0x22 -> cpu_gnt=1, ram_addr=0x20, ram_wren=1, dma_gnt=0, starve_cnt becomes 1.
REQ-039 Scenario: CPU and DMA requesting continuously, STARVE_MAX=4 -> CPU granted in 4 cycles, DMA forced in cycle 5 with cpu_gnt=0, pattern repeats with period 5.
REQ-040 Scenario: CPU read at 0x40 in cycle N, DMA read at 0x41 in cycle N+1 -> cpu_rvalid in N+1 and dma_rvalid in N+2, each with correct data and no cross-delivery.
REQ-041 Scenario: Reset pulsed in the cycle after a DMA read grant -> dma_rvalid=0, starve_cnt=0, no grants during reset; the next request is served normally.
REQ-042 Scenario: idle after a write to 0x77 -> ram_wren=0 and ram_addr stays 0x77.
